n64_console_host: RTL

- Console-side initiator of the N64 joybus protocol: drives the single open-drain data line to issue a command byte to a real controller, then samples the response.
- Supports the poll (0x01) and identity (0x00) commands.
- Sits between the physical controller port and the logic that currently supplies real_controller_data to the controller emulator.
- Its 32-bit poll result is exactly that real_controller_data word. Fixed 50 MHz sys_clk.

---
 rtl/n64_joybus_pkg.sv | 36 +++
 rtl/n64_line_sync.sv | 29 ++
 rtl/n64_console_host.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/n64_joybus_pkg.sv
// Joybus constants, timing multipliers and host FSM state type shared by the
// console-side initiator and the controller-emulator receive path.
package n64_joybus_pkg;

  localparam logic [7:0] CMD_POLL  = 8'h01;
  localparam logic [7:0] CMD_IDENT = 8'h00;

  localparam int unsigned POLL_BITS  = 32;
  localparam int unsigned IDENT_BITS = 24;

  // Bit-cell timing in units of one microsecond (CLK_PER_US cycles).
  localparam int unsigned MUL_BIT      = 4;
  localparam int unsigned MUL_ONE      = 1;
  localparam int unsigned MUL_ZERO     = 3;
  localparam int unsigned MUL_STOP_LOW = 1;
  localparam int unsigned MUL_STOP_REL = 2;
  localparam int unsigned MUL_SAMPLE   = 2;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TX_LOW,
    ST_TX_HIGH,
    ST_TX_STOP,
    ST_RX_WAIT_FALL,
    ST_RX_SAMPLE,
    ST_RX_WAIT_RISE,
    ST_RX_STOP,
    ST_DONE,
    ST_ABORT
  } host_state_e;

  function automatic logic [7:0] cmd_byte(input logic ident);
    return ident ? CMD_IDENT : CMD_POLL;
  endfunction

endpackage

// File: rtl/n64_line_sync.sv
// Joybus data-line synchroniser with falling-edge detect on the synchronised
// level; idles high to match the pulled-up bus.
module n64_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_line,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '1;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_line = r_sync[SYNC_STAGES-1];
  assign o_fall = r_prev & ~r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/n64_console_host.sv
// Console-side joybus initiator: sends a poll or identity command on the
// open-drain line and captures the controller's response.
module n64_console_host
  import n64_joybus_pkg::*;
#(
  parameter int unsigned CLK_PER_US  = 50,
  parameter int unsigned RX_TIMEOUT  = 1000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  inout  wire         n64d,
  input  logic        start,
  input  logic        cmd_ident,
  output logic        busy,
  output logic [31:0] controller_data,
  output logic [23:0] ident_data,
  output logic        data_valid,
  output logic        ident_valid,
  output logic        timeout
);

  localparam logic [10:0] C_ONE_LOW_END   = 11'(MUL_ONE * CLK_PER_US - 1);
  localparam logic [10:0] C_ZERO_LOW_END  = 11'(MUL_ZERO * CLK_PER_US - 1);
  localparam logic [10:0] C_ONE_HIGH_END  = 11'((MUL_BIT - MUL_ONE) * CLK_PER_US - 1);
  localparam logic [10:0] C_ZERO_HIGH_END = 11'((MUL_BIT - MUL_ZERO) * CLK_PER_US - 1);
  localparam logic [10:0] C_STOP_LOW      = 11'(MUL_STOP_LOW * CLK_PER_US);
  localparam logic [10:0] C_STOP_END      = 11'((MUL_STOP_LOW + MUL_STOP_REL) * CLK_PER_US - 1);
  localparam logic [10:0] C_SAMPLE_END    = 11'(MUL_SAMPLE * CLK_PER_US - 1);
  localparam logic [10:0] C_TIMEOUT_END   = 11'(RX_TIMEOUT - 1);

  host_state_e r_state, w_state_next;

  logic [10:0] r_timer, w_timer_next;
  logic [2:0]  r_bitcnt;
  logic [5:0]  r_rxcnt;
  logic [7:0]  r_cmd;
  logic        r_ident;
  logic [31:0] r_shift;
  logic        r_oe, w_oe_next;
  logic        r_stop_fell;
  logic [31:0] r_controller_data;
  logic [23:0] r_ident_data;

  logic        w_line, w_fall;
  logic        w_tx_bit;
  logic [10:0] w_low_end, w_high_end;
  logic        w_rx_expired;
  logic        w_phase_reset;

  n64_line_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_line_sync (
    .i_clk   (sys_clk),
    .i_rst_n (reset_n),
    .i_d     (n64d),
    .o_line  (w_line),
    .o_fall  (w_fall)
  );

  assign w_tx_bit     = r_cmd[r_bitcnt];
  assign w_low_end    = w_tx_bit ? C_ONE_LOW_END : C_ZERO_LOW_END;
  assign w_high_end   = w_tx_bit ? C_ONE_HIGH_END : C_ZERO_HIGH_END;
  assign w_rx_expired = (r_timer == C_TIMEOUT_END);

  always_comb begin
    w_state_next  = r_state;
    w_phase_reset = 1'b0;
    case (r_state)
      ST_IDLE:         if (start) w_state_next = ST_TX_LOW;
      ST_TX_LOW:       if (r_timer == w_low_end) w_state_next = ST_TX_HIGH;
      ST_TX_HIGH: begin
        if (r_timer == w_high_end)
          w_state_next = (r_bitcnt != 3'd0) ? ST_TX_LOW : ST_TX_STOP;
      end
      ST_TX_STOP:      if (r_timer == C_STOP_END) w_state_next = ST_RX_WAIT_FALL;
      ST_RX_WAIT_FALL: begin
        if (w_fall)            w_state_next = ST_RX_SAMPLE;
        else if (w_rx_expired) w_state_next = ST_ABORT;
      end
      ST_RX_SAMPLE: begin
        if (r_timer == C_SAMPLE_END)
          w_state_next = (r_rxcnt == 6'd1) ? ST_RX_STOP : ST_RX_WAIT_RISE;
      end
      ST_RX_WAIT_RISE: begin
        if (w_line)            w_state_next = ST_RX_WAIT_FALL;
        else if (w_rx_expired) w_state_next = ST_ABORT;
      end
      // Two phases (stop-bit fall, then release) share one state; the timer
      // restarts between them so each phase gets its own timeout window.
      ST_RX_STOP: begin
        if (!r_stop_fell) begin
          if (w_fall)            w_phase_reset = 1'b1;
          else if (w_rx_expired) w_state_next  = ST_ABORT;
        end else begin
          if (w_line)            w_state_next = ST_DONE;
          else if (w_rx_expired) w_state_next = ST_ABORT;
        end
      end
      ST_DONE:         w_state_next = ST_IDLE;
      ST_ABORT:        w_state_next = ST_IDLE;
      default:         w_state_next = ST_IDLE;
    endcase

    if (w_state_next == ST_IDLE || w_state_next != r_state || w_phase_reset)
      w_timer_next = '0;
    else
      w_timer_next = r_timer + 11'd1;

    // Output enable follows the next state so the line lags state by zero cycles.
    w_oe_next = (w_state_next == ST_TX_LOW) ||
                ((w_state_next == ST_TX_STOP) && (w_timer_next < C_STOP_LOW));
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_oe        <= 1'b0;
      r_stop_fell <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_timer     <= w_timer_next;
      r_oe        <= w_oe_next;
      r_stop_fell <= (r_state == ST_RX_STOP) && (w_state_next == ST_RX_STOP) &&
                     (r_stop_fell || w_fall);
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bitcnt <= '0;
      r_rxcnt  <= '0;
      r_cmd    <= '0;
      r_ident  <= 1'b0;
      r_shift  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cmd    <= cmd_byte(cmd_ident);
            r_ident  <= cmd_ident;
            r_bitcnt <= 3'd7;
          end
        end
        ST_TX_HIGH: begin
          if (w_state_next == ST_TX_LOW) r_bitcnt <= r_bitcnt - 3'd1;
        end
        ST_TX_STOP: begin
          if (w_state_next == ST_RX_WAIT_FALL)
            r_rxcnt <= r_ident ? 6'(IDENT_BITS) : 6'(POLL_BITS);
        end
        ST_RX_SAMPLE: begin
          if (r_timer == C_SAMPLE_END) begin
            r_shift <= {r_shift[30:0], w_line};
            r_rxcnt <= r_rxcnt - 6'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_controller_data <= '0;
      r_ident_data      <= '0;
    end else if (r_state == ST_RX_STOP && w_state_next == ST_DONE) begin
      if (r_ident) r_ident_data      <= r_shift[23:0];
      else         r_controller_data <= r_shift;
    end
  end

  assign n64d            = r_oe ? 1'b0 : 1'bz;
  assign busy            = (r_state != ST_IDLE);
  assign data_valid      = (r_state == ST_DONE) && !r_ident;
  assign ident_valid     = (r_state == ST_DONE) && r_ident;
  assign timeout         = (r_state == ST_ABORT);
  assign controller_data = r_controller_data;
  assign ident_data      = r_ident_data;

endmodule
